// File: rtl/ser_demux_pkg.sv
// Shared types and elaboration helpers for the parametrised serial frame demultiplexer.
package ser_demux_pkg;

    // One-hot so each state decode is a single flop bit.
    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        ADDR = 6'b000010,
        LEN  = 6'b000100,
        DATA = 6'b001000,
        PAR  = 6'b010000,
        DONE = 6'b100000
    } state_e;

    function automatic bit ch_num_fits(input int ch_num, input int addr_w);
        return (ch_num >= 2) && (ch_num <= 16) && (ch_num <= (1 << addr_w));
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ser_field_shifter.sv
// MSB-first field shift register with a bit counter; value reflects the bit shifted this step.
module ser_field_shifter
    import ser_demux_pkg::*;
#(
    parameter int W     = 2,
    parameter int CNT_W = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0]     value_q, value_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    if (W == 1) begin : g_w1
        assign shifted = din;
    end else begin : g_wn
        assign shifted = {value_q[W-2:0], din};
    end

    assign last  = (cnt_q == CNT_W'(W - 1));
    assign value = value_d;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (en) begin
            value_d = shifted;
            cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ser_demux_param.sv
// Framed serial-to-parallel demultiplexer: start, address, length, data, optional even parity.
module ser_demux_param
    import ser_demux_pkg::*;
#(
    parameter int CH_NUM    = 4,
    parameter int ADDR_W    = 2,
    parameter int LEN_W     = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              ser_in,
    output logic [CH_NUM-1:0] p,
    output logic              ser_out_valid,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  data_num
);

    localparam int              CNT_W      = max_w(ADDR_W, LEN_W);
    localparam logic [ADDR_W:0] CH_LIM     = (ADDR_W + 1)'(CH_NUM);
    localparam state_e          AFTER_DATA = (PARITY_EN != 0) ? PAR : DONE;

    if (!ch_num_fits(CH_NUM, ADDR_W)) begin : g_bad_cfg
        $error("ser_demux_param: CH_NUM must be 2..16 and fit in ADDR_W bits");
    end

    state_e             state_q, state_d;
    logic               err_q, err_d;
    logic               par_q, par_d;
    logic [LEN_W-1:0]   data_num_q, data_num_d;
    logic               fld_clr, addr_en, len_en, addr_last, len_last, addr_bad;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;

    ser_field_shifter #(.W(ADDR_W), .CNT_W(CNT_W)) u_addr (
        .clk(clk), .rst(rst), .clr(fld_clr), .en(addr_en), .din(ser_in),
        .value(addr), .last(addr_last)
    );

    ser_field_shifter #(.W(LEN_W), .CNT_W(CNT_W)) u_len (
        .clk(clk), .rst(rst), .clr(fld_clr), .en(len_en), .din(ser_in),
        .value(len), .last(len_last)
    );

    assign addr_bad = ({1'b0, addr} >= CH_LIM);

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        par_d      = par_q;
        data_num_d = data_num_q;
        fld_clr    = 1'b0;
        addr_en    = 1'b0;
        len_en     = 1'b0;
        if (clk_en) begin
            case (state_q)
                IDLE: if (!ser_in) begin
                    state_d = ADDR;
                    err_d   = 1'b0;
                    par_d   = 1'b0;
                    fld_clr = 1'b1;
                end
                ADDR: begin
                    addr_en = 1'b1;
                    if (addr_last) begin
                        state_d = LEN;
                        err_d   = err_q | addr_bad;
                    end
                end
                LEN: begin
                    len_en = 1'b1;
                    if (len_last) begin
                        data_num_d = len;
                        state_d    = (len != '0) ? DATA : AFTER_DATA;
                    end
                end
                DATA: begin
                    par_d      = par_q ^ ser_in;
                    data_num_d = data_num_q - LEN_W'(1);
                    if (data_num_q == LEN_W'(1)) state_d = AFTER_DATA;
                end
                PAR: begin
                    err_d   = err_q | (par_q ^ ser_in);
                    state_d = DONE;
                end
                // A start bit arriving during DONE is deliberately ignored.
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            par_q      <= 1'b0;
            data_num_q <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            par_q      <= par_d;
            data_num_q <= data_num_d;
        end
    end

    always_comb begin
        p = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            p[i] = (state_q == DATA) && (addr == ADDR_W'(i)) && ser_in;
        end
    end

    assign ser_out_valid = (state_q == DATA) && !addr_bad;
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign data_num      = data_num_q;

endmodule

// File: doc/ser_demux_param.md
Name: ser_demux_param

Overview:
Parametrised serial-to-parallel frame demultiplexer; successor of the fixed 4-port serial demux.
Receives a framed bit stream on ser_in and steers its data bits to one of CH_NUM output channels.
Adds configurable field widths, an optional even-parity check, and an error flag for bad address or parity.
Advances only on clk_en strobes from the existing one-pulser; data_num feeds the external SSD decoders.

Parameters:
CH_NUM, 4, number of output channels (2..16)
ADDR_W, 2, address field width; CH_NUM <= 2**ADDR_W
LEN_W, 4, length field width; a frame carries 0..2**LEN_W-1 data bits
PARITY_EN, 1, 1 = frame ends with one even-parity bit over the data bits; 0 = no parity bit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
clk_en  in  1  single-cycle step strobe; all state/field updates occur only on clk edges with clk_en=1
ser_in  in  1  serial frame input, sampled on clk_en
p  out  CH_NUM  channel outputs; p[addr] mirrors ser_in during DATA
ser_out_valid  out  1  high while in DATA with a valid address
done  out  1  high while in DONE
err  out  1  sticky frame error; cleared on the next accepted start bit
data_num  out  LEN_W  data bits remaining in the current frame

Behaviour:
- Reset (rst=0, async): state=IDLE, addr=0, data_num=0, parity accumulator=0, err=0; p=0, ser_out_valid=0, done=0.
- Frame format, MSB first: start bit (0), ADDR_W address bits, LEN_W length bits, L data bits, parity bit if PARITY_EN=1.
- State transitions (evaluated only when clk_en=1):
  - IDLE: ser_in=0 -> ADDR; clear err, bit counter and parity accumulator.
  - ADDR: shift ser_in into addr; after ADDR_W bits -> LEN.
  - LEN: shift ser_in into data_num; after LEN_W bits -> DATA if the length is nonzero, else PAR (PARITY_EN=1) or DONE.
  - DATA: parity ^= ser_in; data_num -= 1; when data_num reaches 0 -> PAR (PARITY_EN=1) or DONE.
  - PAR: err |= (parity ^ ser_in); -> DONE.
  - DONE: -> IDLE on the next clk_en. A start bit is not accepted in this same step.
- Bits shifted on a strobe are visible on the following clk cycle.
- p, ser_out_valid and done are combinational from registered state and ser_in:
  - p[i] = ser_in when state=DATA and addr=i (i < CH_NUM); all other bits 0.
  - ser_out_valid = (state==DATA) and (addr < CH_NUM).
- Invalid address (addr >= CH_NUM): set err on leaving ADDR; the frame is still consumed fully; p stays 0.
- Length 0: no DATA cycles; the parity bit, if present, is checked against 0.
- clk_en=0 freezes all state; ser_in changes while clk_en=0 only affect the combinational p outputs.
- data_num counts down from L to 0 in DATA and holds at 0 in PAR, DONE and IDLE until the next LEN load.
- Reset mid-frame: immediate return to IDLE; the partial frame is discarded and err is cleared.
- Bit counter width is max(ADDR_W, LEN_W); no wrap inside a field.

Decomposition:
- Shared package ser_demux_pkg holds:
  - the state enum (IDLE, ADDR, LEN, DATA, PAR, DONE), one-hot localparam encoding;
  - a field-width sanity check (CH_NUM <= 2**ADDR_W).
- One sub-module, ser_field_shifter: parametrised MSB-first shift register plus bit counter, with load/enable and a last-bit flag.
  - Instantiated once for the address field and once for the length field.
- FSM and data counter stay in the top module.

Test Plan:
- CH_NUM=4, PARITY_EN=1; with clk_en every cycle, send start, addr 10, len 0011, data 101, parity 0.
  -> p[2] follows 1,0,1 on three strobes, ser_out_valid high 3 strobes, data_num 3->2->1->0, done for one strobe, err=0.
- Same frame with parity bit 1 -> data routed to p[2] as before; err=1 after PAR; err clears on the next start bit.
- CH_NUM=3, addr 11, len 0010 -> p stays 000, ser_out_valid=0, err=1, frame consumed, then IDLE.
- len 0000, PARITY_EN=0 -> LEN goes directly to DONE; no p activity; done high one strobe.
- Assert rst=0 asynchronously during DATA at data_num=5 -> all outputs 0 immediately; a following clean frame decodes correctly.
- clk_en pulsing every 7 cycles with ser_in toggling between strobes -> state advances only on strobes; captured bits match the strobe-time values.
